// File: rtl/slr_link_arbiter_if.sv
// Bundle of requester, launch and credit signals between the requesters/crossing and the link arbiter.
// The master side is the requesters plus the far-side credit source; the slave side is the arbiter.
interface slr_link_arbiter_if #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned CREDITS = 8
);
  localparam int unsigned ID_W  = $clog2(N_REQ);
  localparam int unsigned CNT_W = $clog2(CREDITS + 1);

  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ*WIDTH-1:0] req_data;
  logic [N_REQ-1:0]       req_ready;
  logic                   link_valid;
  logic [WIDTH-1:0]       link_data;
  logic [ID_W-1:0]        link_id;
  logic                   credit_return;
  logic [CNT_W-1:0]       credits_avail;
  logic                   credit_err;

  modport master (
    output req_valid, req_data, credit_return,
    input  req_ready, link_valid, link_data, link_id, credits_avail, credit_err
  );

  modport slave (
    input  req_valid, req_data, credit_return,
    output req_ready, link_valid, link_data, link_id, credits_avail, credit_err
  );
endinterface

// File: rtl/slr_link_arbiter.sv
// Round-robin arbiter sharing one registered SLR-crossing channel, with credit-based flow control
// against the far-side receive FIFO. Each launched word carries its source index.
module slr_link_arbiter #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned CREDITS = 8
) (
  input  logic             clk,
  input  logic             areset,
  slr_link_arbiter_if.slave bus
);
  localparam int unsigned ID_W  = $clog2(N_REQ);
  localparam int unsigned CNT_W = $clog2(CREDITS + 1);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CREDITS);
  localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(N_REQ - 1);

  logic [ID_W-1:0]  rr_ptr;
  logic [CNT_W-1:0] credits;
  logic             err;
  logic             link_valid_q;
  logic [WIDTH-1:0] link_data_q;
  logic [ID_W-1:0]  link_id_q;

  logic [N_REQ-1:0] grant;
  logic [ID_W-1:0]  grant_id;
  logic             found;
  logic [ID_W:0]    pos_sum;
  logic [ID_W-1:0]  pos;
  logic             xfer;
  logic [WIDTH-1:0] xfer_data;
  logic [ID_W-1:0]  ptr_next;

  // Rotating priority search from rr_ptr; only when a credit is already held
  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    pos_sum  = '0;
    pos      = '0;
    if (credits != '0 && !areset) begin
      for (int k = 0; k < N_REQ; k++) begin
        pos_sum = {1'b0, rr_ptr} + (ID_W+1)'(k);
        if (pos_sum >= (ID_W+1)'(N_REQ)) begin
          pos_sum = pos_sum - (ID_W+1)'(N_REQ);
        end
        pos = ID_W'(pos_sum);
        if (!found && bus.req_valid[pos]) begin
          found       = 1'b1;
          grant[pos]  = 1'b1;
          grant_id    = pos;
        end
      end
    end
  end

  // Payload mux driven by the one-hot grant
  always_comb begin
    xfer_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        xfer_data = xfer_data | bus.req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign xfer     = found;
  assign ptr_next = (grant_id == ID_LAST) ? '0 : grant_id + ID_W'(1);

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      rr_ptr <= '0;
    end else if (xfer) begin
      rr_ptr <= ptr_next;
    end
  end

  // Launch register feeding the crossing pipeline; data/id hold when idle
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      link_valid_q <= 1'b0;
      link_data_q  <= '0;
      link_id_q    <= '0;
    end else begin
      link_valid_q <= xfer;
      if (xfer) begin
        link_data_q <= xfer_data;
        link_id_q   <= grant_id;
      end
    end
  end

  // A return arriving at a full counter is a protocol error from the far side
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      credits <= CNT_FULL;
      err     <= 1'b0;
    end else begin
      case ({xfer, bus.credit_return})
        2'b10: credits <= credits - CNT_W'(1);
        2'b01: begin
          if (credits == CNT_FULL) begin
            err <= 1'b1;
          end else begin
            credits <= credits + CNT_W'(1);
          end
        end
        default: credits <= credits;
      endcase
    end
  end

  assign bus.req_ready     = grant;
  assign bus.link_valid    = link_valid_q;
  assign bus.link_data     = link_data_q;
  assign bus.link_id       = link_id_q;
  assign bus.credits_avail = credits;
  assign bus.credit_err    = err;
endmodule

// File: tb/tb_slr_link_arbiter.sv
// Directed bench for slr_link_arbiter: reset, single requester, round robin, credit limits, error flag.
module tb_slr_link_arbiter;
  localparam int unsigned N_REQ   = 4;
  localparam int unsigned WIDTH   = 16;
  localparam int unsigned CREDITS = 8;

  logic clk;
  logic areset;
  int   n_tests;
  int   n_fail;

  slr_link_arbiter_if #(.N_REQ(N_REQ), .WIDTH(WIDTH), .CREDITS(CREDITS)) bus ();

  slr_link_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH), .CREDITS(CREDITS)) dut (
    .clk    (clk),
    .areset (areset),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    areset            = 1'b1;
    bus.req_valid     = '0;
    bus.credit_return = 1'b0;
    tick();
    tick();
    areset = 1'b0;
    settle();
  endtask

  initial begin
    n_tests           = 0;
    n_fail            = 0;
    areset            = 1'b1;
    bus.req_valid     = '0;
    bus.credit_return = 1'b0;
    for (int i = 0; i < N_REQ; i++) bus.req_data[i*WIDTH +: WIDTH] = 16'(32'h1000 + i);

    // reset values, with requests present while reset is high
    tick();
    bus.req_valid = 4'b1111;
    settle();
    check("rst_ready",   32'(bus.req_ready), 0);
    check("rst_lvalid",  32'(bus.link_valid), 0);
    check("rst_ldata",   32'(bus.link_data), 0);
    check("rst_lid",     32'(bus.link_id), 0);
    check("rst_credits", 32'(bus.credits_avail), 8);
    check("rst_err",     32'(bus.credit_err), 0);
    do_reset();

    // single requester 2, no returns: 8 words then stall
    bus.req_data[2*WIDTH +: WIDTH] = 16'hA002;
    bus.req_valid = 4'b0100;
    for (int c = 0; c < 10; c++) begin
      settle();
      check($sformatf("single_ready_c%0d", c), 32'(bus.req_ready), (c < 8) ? 32'h4 : 32'h0);
      check($sformatf("single_cred_c%0d", c), 32'(bus.credits_avail), (c < 8) ? 32'(8 - c) : 32'h0);
      check($sformatf("single_lvalid_c%0d", c), 32'(bus.link_valid), (c >= 1 && c <= 8) ? 32'h1 : 32'h0);
      if (c >= 1 && c <= 8) begin
        check($sformatf("single_lid_c%0d", c), 32'(bus.link_id), 2);
        check($sformatf("single_ldata_c%0d", c), 32'(bus.link_data), 32'hA002);
      end
      tick();
    end

    // credit return at zero: no grant that cycle, exactly one afterwards
    bus.credit_return = 1'b1;
    settle();
    check("ret0_ready", 32'(bus.req_ready), 0);
    check("ret0_cred",  32'(bus.credits_avail), 0);
    tick();
    bus.credit_return = 1'b0;
    settle();
    check("ret1_cred",   32'(bus.credits_avail), 1);
    check("ret1_ready",  32'(bus.req_ready), 4);
    check("ret1_lvalid", 32'(bus.link_valid), 0);
    tick();
    settle();
    check("ret2_cred",   32'(bus.credits_avail), 0);
    check("ret2_ready",  32'(bus.req_ready), 0);
    check("ret2_lvalid", 32'(bus.link_valid), 1);
    check("ret2_lid",    32'(bus.link_id), 2);

    // simultaneous transfer and return at 3, then overflow return at 8
    do_reset();
    bus.req_valid = 4'b0100;
    for (int c = 0; c < 5; c++) tick();
    settle();
    check("both_pre_cred", 32'(bus.credits_avail), 3);
    bus.credit_return = 1'b1;
    settle();
    check("both_ready", 32'(bus.req_ready), 4);
    tick();
    settle();
    check("both_cred", 32'(bus.credits_avail), 3);
    bus.req_valid = 4'b0000;
    for (int c = 0; c < 5; c++) tick();
    settle();
    check("refill_cred", 32'(bus.credits_avail), 8);
    check("refill_err",  32'(bus.credit_err), 0);
    tick();
    bus.credit_return = 1'b0;
    settle();
    check("over_cred", 32'(bus.credits_avail), 8);
    check("over_err",  32'(bus.credit_err), 1);
    tick();
    tick();
    settle();
    check("over_err_sticky", 32'(bus.credit_err), 1);
    do_reset();
    check("over_err_cleared", 32'(bus.credit_err), 0);

    // all requesters valid, returns from cycle 4 on: 0,1,2,3,... without bubbles
    for (int i = 0; i < N_REQ; i++) bus.req_data[i*WIDTH +: WIDTH] = 16'(32'h1000 + i);
    bus.req_valid = 4'b1111;
    for (int c = 0; c < 14; c++) begin
      bus.credit_return = (c >= 4);
      settle();
      check($sformatf("rr_ready_c%0d", c), 32'(bus.req_ready), 32'(1) << (c % 4));
      check($sformatf("rr_cred_c%0d", c), 32'(bus.credits_avail), (c <= 4) ? 32'(8 - c) : 32'h4);
      if (c >= 1) begin
        check($sformatf("rr_lvalid_c%0d", c), 32'(bus.link_valid), 1);
        check($sformatf("rr_lid_c%0d", c), 32'(bus.link_id), 32'((c - 1) % 4));
        check($sformatf("rr_ldata_c%0d", c), 32'(bus.link_data), 32'h1000 + 32'((c - 1) % 4));
      end
      tick();
    end

    // asynchronous reset mid-traffic
    #2;
    areset = 1'b1;
    #1;
    check("mid_rst_ready",  32'(bus.req_ready), 0);
    check("mid_rst_cred",   32'(bus.credits_avail), 8);
    check("mid_rst_lvalid", 32'(bus.link_valid), 0);
    check("mid_rst_lid",    32'(bus.link_id), 0);
    tick();
    settle();
    check("mid_rst_hold_ready", 32'(bus.req_ready), 0);
    check("mid_rst_hold_cred",  32'(bus.credits_avail), 8);
    do_reset();

    // sparse requests 1010, then requester 0 joins
    bus.req_valid = 4'b1010;
    settle();
    check("sparse_g0", 32'(bus.req_ready), 4'b0010);
    tick();
    settle();
    check("sparse_g1", 32'(bus.req_ready), 4'b1000);
    check("sparse_l1", 32'(bus.link_id), 1);
    tick();
    settle();
    check("sparse_g2", 32'(bus.req_ready), 4'b0010);
    check("sparse_l2", 32'(bus.link_id), 3);
    tick();
    bus.req_valid = 4'b1011;
    settle();
    check("sparse_g3", 32'(bus.req_ready), 4'b1000);
    tick();
    settle();
    check("sparse_g4", 32'(bus.req_ready), 4'b0001);
    tick();
    settle();
    check("sparse_g5", 32'(bus.req_ready), 4'b0010);
    check("sparse_l5", 32'(bus.link_id), 0);
    check("sparse_d5", 32'(bus.link_data), 32'h1000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
